// File: rtl/pulse_channels.sv
// Multi-channel button front end: each channel is synchronised, debounced and edge-qualified
// into a fixed-length pulse; a shared counter tallies every accepted event.
module pulse_channels #(
  parameter int N_CH         = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4,
  parameter int PULSE_LEN    = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clk_pi,
  input  logic             rst_n_pi,
  input  logic [N_CH-1:0]  button_pi,
  input  logic [1:0]       mode_pi,
  output logic [N_CH-1:0]  pulse_po,
  output logic [N_CH-1:0]  busy_po,
  output logic [CNT_W-1:0] event_cnt_po
);

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int PW = $clog2(N_CH + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [7:0]    PLEN_LOAD = 8'(PULSE_LEN - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_t;

  logic [N_CH-1:0]  start_s;
  logic [N_CH-1:0]  pulse_s;
  logic [PW-1:0]    start_cnt_s;
  logic [CNT_W-1:0] event_cnt_r;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic                   deb_r;
    logic [DW-1:0]          dcnt_r;
    logic                   flip_s;
    logic                   qual_s;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [7:0]             plen_r;
    logic [7:0]             plen_nxt_s;
    logic                   ch_start_s;
    logic                   ch_pulse_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser shift chain for the raw button level
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
        sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], button_pi[ch]};
      end
    end

    // Debouncer: deb follows sync only after DEBOUNCE_CYC consecutive differing cycles
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
        deb_r  <= 1'b0;
        dcnt_r <= {DW{1'b0}};
      end else if (sync_s == deb_r) begin
        dcnt_r <= {DW{1'b0}};
      end else if (dcnt_r == DCNT_LAST) begin
        deb_r  <= sync_s;
        dcnt_r <= {DW{1'b0}};
      end else begin
        dcnt_r <= dcnt_r + DW'(1);
      end
    end

    // The edge is qualified in the very cycle deb flips, so the pulse rises with deb
    assign flip_s = (sync_s != deb_r) && (dcnt_r == DCNT_LAST);

    // Edge qualification against the run-time polarity select
    always_comb begin
      qual_s = 1'b0;
      case (mode_pi)
        MODE_RISE: qual_s = flip_s && sync_s;
        MODE_FALL: qual_s = flip_s && !sync_s;
        MODE_BOTH: qual_s = flip_s;
        default:   qual_s = 1'b0;
      endcase
    end

    // Channel FSM state and pulse length register
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
        state_r <= ST_IDLE;
        plen_r  <= 8'd0;
      end else begin
        state_r <= state_nxt_s;
        plen_r  <= plen_nxt_s;
      end
    end

    // Channel FSM next state; edges outside IDLE are simply dropped
    always_comb begin
      state_nxt_s = state_r;
      plen_nxt_s  = plen_r;
      ch_start_s  = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (qual_s) begin
            state_nxt_s = ST_PULSE;
            plen_nxt_s  = PLEN_LOAD;
            ch_start_s  = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_PULSE: begin
          if (plen_r == 8'd0) begin
            state_nxt_s = ST_IDLE;
          end else begin
            plen_nxt_s = plen_r - 8'd1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          plen_nxt_s  = 8'd0;
        end
      endcase
    end

    // Channel FSM output decode straight from the state flop
    always_comb begin
      ch_pulse_s = (state_r == ST_PULSE);
    end

    assign start_s[ch] = ch_start_s;
    assign pulse_s[ch] = ch_pulse_s;
  end

  // Number of channels starting a pulse this cycle
  always_comb begin
    start_cnt_s = {PW{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      start_cnt_s = start_cnt_s + PW'(start_s[i]);
    end
  end

  // Shared event counter, wrapping naturally at its width
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      event_cnt_r <= {CNT_W{1'b0}};
    end else begin
      event_cnt_r <= event_cnt_r + CNT_W'(start_cnt_s);
    end
  end

  assign pulse_po     = pulse_s;
  assign busy_po      = pulse_s;
  assign event_cnt_po = event_cnt_r;

endmodule

// File: tb/tb_pulse_channels.sv
// Bench for pulse_channels: two instances (pulse length 3 and 10) share stimulus and are
// checked every cycle against a window-based behavioural model, plus literal expectations.
module tb_pulse_channels;
  localparam int N = 4;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] button = '0;
  logic [1:0]   mode = 2'b00;
  logic [N-1:0] p3, b3, p10, b10;
  logic [7:0]   c3, c10;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pulse_channels #(.N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYC(D), .PULSE_LEN(3), .CNT_W(8)) dut3 (
    .clk_pi(clk), .rst_n_pi(rst_n), .button_pi(button), .mode_pi(mode),
    .pulse_po(p3), .busy_po(b3), .event_cnt_po(c3));

  pulse_channels #(.N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYC(D), .PULSE_LEN(10), .CNT_W(8)) dut10 (
    .clk_pi(clk), .rst_n_pi(rst_n), .button_pi(button), .mode_pi(mode),
    .pulse_po(p10), .busy_po(b10), .event_cnt_po(c10));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // deb toggles when the last D synchronised samples all differ from it; a pulse occupies
  // edges [start, last]; a new one may start only when the channel was idle before the edge.
  int         plen_m[2] = '{3, 10};
  logic [N-1:0] hist[$];
  bit         deb_m[N];
  int         start_m[2][N];
  int         last_m[2][N];
  int         cnt_m[2];
  int         edge_n = 0;

  function automatic bit samp(int m, int ch);
    int idx = hist.size() - 1 - m;
    if (idx < 0) return 1'b0;
    return hist[idx][ch];
  endfunction

  task automatic model_step();
    bit stable, rising, qual;
    edge_n++;
    if (!rst_n) begin
      hist.delete();
      for (int c = 0; c < N; c++) begin
        deb_m[c] = 1'b0;
        for (int i = 0; i < 2; i++) begin
          start_m[i][c] = -100;
          last_m[i][c]  = -100;
        end
      end
      cnt_m[0] = 0;
      cnt_m[1] = 0;
    end else begin
      hist.push_back(button);
      if (hist.size() > 32) void'(hist.pop_front());
      for (int c = 0; c < N; c++) begin
        stable = 1'b1;
        for (int m = S; m < S + D; m++) if (samp(m, c) == deb_m[c]) stable = 1'b0;
        if (stable) begin
          deb_m[c] = !deb_m[c];
          rising = deb_m[c];
          qual = (mode == 2'b10) || (mode == 2'b00 && rising) || (mode == 2'b01 && !rising);
          for (int i = 0; i < 2; i++) begin
            if (qual && edge_n > last_m[i][c] + 1) begin
              start_m[i][c] = edge_n;
              last_m[i][c]  = edge_n + plen_m[i] - 1;
              cnt_m[i]      = (cnt_m[i] + 1) % 256;
            end
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of both instances against the model
  initial forever begin
    logic [N-1:0] ep[2];
    logic [7:0]   ec[2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ep[i] = '0;
      ec[i] = 8'(cnt_m[i]);
      for (int c = 0; c < N; c++)
        ep[i][c] = (edge_n >= start_m[i][c]) && (edge_n <= last_m[i][c]);
      if (!rst_n) begin
        ep[i] = '0;
        ec[i] = 8'd0;
      end
    end
    check("dut3.pulse", 32'(p3), 32'(ep[0]));
    check("dut3.busy", 32'(b3), 32'(ep[0]));
    check("dut3.cnt", 32'(c3), 32'(ec[0]));
    check("dut10.pulse", 32'(p10), 32'(ep[1]));
    check("dut10.busy", 32'(b10), 32'(ep[1]));
    check("dut10.cnt", 32'(c10), 32'(ec[1]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Counts edges until all mask bits of the chosen instance are high (bounded)
  task automatic wait_rise(input int inst, input logic [N-1:0] mask, output int n,
                           output logic [7:0] prev);
    logic [N-1:0] p;
    n = 0;
    prev = (inst == 0) ? c3 : c10;
    do begin
      if (n > 0) prev = (inst == 0) ? c3 : c10;
      @(posedge clk);
      #1;
      n++;
      p = (inst == 0) ? p3 : p10;
    end while ((p & mask) != mask && n < 40);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

  int mexp[4] = '{1, 1, 2, 0};

  initial begin
    int n, w, hi3, hi10;
    logic [7:0] prev, base;

    // Reset and single press
    cyc(3);
    check("rst.pulse3", 32'(p3), 32'h0);
    check("rst.pulse10", 32'(p10), 32'h0);
    check("rst.cnt3", 32'(c3), 32'h0);
    rst_n = 1'b1;
    cyc(2);
    button[0] = 1'b1;
    wait_rise(0, 4'b0001, n, prev);
    check("press.latency", 32'(n), 32'd6);
    check("press.only_ch0", 32'(p3), 32'h1);
    w = 1;
    while (w < 20) begin
      @(posedge clk);
      #1;
      if (p3[0]) w++;
      else break;
    end
    check("press.width", 32'(w), 32'd3);
    cyc(12);
    button[0] = 1'b0;
    cyc(10);
    check("press.cnt3", 32'(c3), 32'd1);
    check("press.cnt10", 32'(c10), 32'd1);

    // Bounce on channel 1
    base = c3;
    for (int k = 0; k < 6; k++) begin
      button[1] = ~button[1];
      cyc(2);
    end
    check("bounce.no_event", 32'(c3), 32'(base));
    button[1] = 1'b1;
    wait_rise(0, 4'b0010, n, prev);
    check("bounce.latency", 32'(n), 32'd6);
    cyc(10);
    check("bounce.cnt", 32'(c3), 32'(base + 8'd1));
    button[1] = 1'b0;
    cyc(10);

    // Edge modes on channel 2
    for (int md = 0; md < 4; md++) begin
      mode = 2'(md);
      base = c3;
      button[2] = 1'b1;
      cyc(20);
      button[2] = 1'b0;
      cyc(20);
      check("mode.events", 32'(8'(c3 - base)), 32'(mexp[md]));
    end

    // Simultaneous rise on all channels
    mode = 2'b00;
    base = c3;
    button = 4'hF;
    wait_rise(0, 4'hF, n, prev);
    check("simul.latency", 32'(n), 32'd6);
    check("simul.all", 32'(p3), 32'hF);
    check("simul.prev", 32'(prev), 32'(base));
    check("simul.jump", 32'(c3), 32'(base + 8'd4));
    cyc(15);
    button = 4'h0;
    cyc(10);

    // Counter wrap 254 -> 2
    do_reset();
    mode = 2'b10;
    button[0] = 1'b1;
    cyc(12);
    button[0] = 1'b0;
    cyc(12);
    check("wrap.pre2", 32'(c3), 32'd2);
    for (int k = 0; k < 63; k++) begin
      button = ~button;
      cyc(10);
    end
    check("wrap.254", 32'(c3), 32'd254);
    button = ~button;
    wait_rise(0, 4'hF, n, prev);
    check("wrap.prev", 32'(prev), 32'd254);
    check("wrap.after", 32'(c3), 32'd2);
    cyc(10);

    // Edge during pulse: PULSE_LEN=10 keeps one pulse, PULSE_LEN=3 sees two
    button = 4'h0;
    cyc(10);
    do_reset();
    mode = 2'b10;
    button[3] = 1'b1;
    hi3 = 0;
    hi10 = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      hi3 += int'(p3[3]);
      hi10 += int'(p10[3]);
      if (i == 5) begin
        #1;
        button[3] = 1'b0;
      end
    end
    check("during.width10", 32'(hi10), 32'd10);
    check("during.cnt10", 32'(c10), 32'd1);
    check("during.width3", 32'(hi3), 32'd6);
    check("during.cnt3", 32'(c3), 32'd2);

    // Reset mid-pulse with the button still held
    mode = 2'b00;
    cyc(2);
    button[0] = 1'b1;
    wait_rise(0, 4'b0001, n, prev);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.pulse3", 32'(p3), 32'h0);
    check("midrst.pulse10", 32'(p10), 32'h0);
    check("midrst.cnt3", 32'(c3), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    wait_rise(0, 4'b0001, n, prev);
    check("midrst.relatency", 32'(n), 32'd6);
    check("midrst.cnt", 32'(c3), 32'd1);
    button = 4'h0;
    cyc(10);

    // Randomised traffic, checked cycle by cycle against the model
    for (int i = 0; i < 2500; i++) begin
      cyc(1);
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 6) == 0) button[c] = ~button[c];
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
    end
    rst_n = 1'b1;
    cyc(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
